maxunpool_1: RTL and testbench
==============================

Name: maxunpool_1

Overview:
- Streaming max-unpool (inverse of the 2x2 stride-2 max-pooling stage) for the 2-channel feature path.
- Accepts 14x14 pooled values, each with a 2-bit argmax position code.
- Emits the 28x28 map in raster order per channel (channel 0 then channel 1); each value lands at its argmax position of the 2x2 window, zeros elsewhere.
- Sits on the decoder/backward side of the pooling layer; output feeds the next up-sampling/convolution stage.

Parameters:
- bitwidth, 16, signed data width of pooled and unpooled values.
- pool_dim, 14, pooled map side; output side is 2*pool_dim.
- num_ch, 2, channels per frame, processed sequentially.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  pooled element available.
- in_ready  output  1  block accepts pooled element this cycle.
- in_data  input  bitwidth  signed pooled value.
- in_idx  input  2  argmax code: 0=(2i,2j), 1=(2i+1,2j), 2=(2i,2j+1), 3=(2i+1,2j+1); i.e. code = {col lsb, row lsb}.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  bitwidth  signed unpooled value.
- out_ch  output  1  channel of current beat.
- out_row  output  5  row 0..27.
- out_col  output  5  col 0..27.
- out_last  output  1  high on final beat of frame (ch num_ch-1, row 27, col 27).

Behaviour:
- Reset (synchronous, rst high at clk edge): out_valid=0, out_data=0, out_ch/out_row/out_col=0, out_last=0, in_ready=0 for that cycle, state=TOP, counters=0. Line buffer contents are don't-care. Reset mid-frame abandons the frame; the next accepted input is element (ch0, 0, 0).
- Output register: one stage. Slot is "free" when out_valid=0 or out_ready=1. A beat is transferred when out_valid && out_ready. While stalled, out_* hold stable.
- Phase TOP (even output row 2i):
  - At even output col 2j: in_ready = slot free. On in_valid && in_ready, store {in_data, in_idx} to line_buf[j] and load beat (row 2i, col 2j) into the output register.
  - At odd col 2j+1: in_ready=0; load beat from line_buf[j] when slot free.
- Phase BOT (odd row 2i+1): in_ready=0. Load beats for cols 0..27 from line_buf[col>>1], one per cycle when slot free.
- Beat value: out_data = (entry.idx == {col[0], row[0]}) ? entry.value : 0.
- Transitions:
  - TOP -> BOT after col 27 is loaded.
  - BOT -> TOP after col 27 is loaded; i increments.
  - After row 27: ch increments and i=0. After the last channel, wrap to ch0 and start the next frame.
- Latency: input accept -> out_valid next cycle.
- Throughput: 1 beat/cycle with out_ready held high. A full frame = num_ch*784 beats plus 1 cycle of fill.
- Simultaneous events: a transfer and a load in the same cycle are legal (back-to-back). in_valid while in_ready=0 is ignored; the upstream holds its data.

Optional Feature:
- MAXUNPOOL_NEAREST_EN.
- Defined: nearest-neighbour upsample; in_idx is ignored and all four window positions output entry.value. Handshake, timing and counters are unchanged.
- Undefined: argmax placement as above.

Decomposition:
- maxpool_pkg holds: bitwidth default, POOL_DIM=14, FMAP_DIM=28, NUM_CH=2, the pos-code typedef (2-bit enum POS_TL, POS_BL, POS_TR, POS_BR), the unpool phase enum {TOP, BOT}, and the line-buffer entry struct {value, idx}.
- Sub-module unpool_line_buf: pool_dim-entry register file, 1 write port and 1 async read port.

Test Plan:
- Reset then 392 inputs per frame with value=i*14+j+1 and idx=3, out_ready=1 -> only odd/odd positions nonzero; beat (ch0, 1, 1)=1; (ch0, 27, 27)=196; out_last only on beat 1567.
- idx pattern 0,1,2,3 repeating, value=-5 -> window j=1 has -5 at (1, 2) and zeros at (0, 2), (0, 3), (1, 3); negative values pass through sign-intact.
- Toggle out_ready every other cycle -> no beat lost or duplicated, out_* stable while stalled, in_ready=0 throughout the BOT phase.
- Assert rst at beat 500 of channel 0 -> out_valid=0 the next cycle; the following input appears as beat (ch0, 0, 0).
- Run 2 frames back-to-back -> ch wraps 1->0, row/col restart at 0, no extra idle cycles with in_valid held.
- With MAXUNPOOL_NEAREST_EN defined, input value 7 with idx=2 -> all four window beats equal 7.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and sizes for the 2x2 max-pool / max-unpool feature path.
package maxpool_pkg;

  localparam int BITWIDTH = 16;
  localparam int POOL_DIM = 14;
  localparam int FMAP_DIM = 2 * POOL_DIM;
  localparam int NUM_CH   = 2;

  // Argmax position inside a 2x2 window, encoded as {col lsb, row lsb}.
  typedef enum logic [1:0] {
    POS_TL = 2'd0,
    POS_BL = 2'd1,
    POS_TR = 2'd2,
    POS_BR = 2'd3
  } pos_t;

  typedef enum logic {
    TOP = 1'b0,
    BOT = 1'b1
  } phase_t;

  typedef struct packed {
    logic signed [BITWIDTH-1:0] value;
    pos_t                       idx;
  } lb_entry_t;

  function automatic pos_t pos_of(input logic row_lsb, input logic col_lsb);
    return pos_t'({col_lsb, row_lsb});
  endfunction

endpackage

// File: rtl/unpool_line_buf.sv
// One pooled row of {value, idx} entries: registered write, combinational read.
// Latency: write visible on the read port the cycle after it is clocked in; no backpressure.
module unpool_line_buf #(
  parameter int depth = 14,
  parameter int width = 18,
  parameter int aw    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxunpool_1.sv
// Streaming 2x2 max-unpool, 14x14 pooled -> 28x28 raster per channel; one output register stage.
// Input accepted only at even row/even col with a free output slot; MAXUNPOOL_NEAREST_EN replicates values.
module maxunpool_1
  import maxpool_pkg::*;
#(
  parameter int bitwidth = BITWIDTH,
  parameter int pool_dim = POOL_DIM,
  parameter int num_ch   = NUM_CH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [bitwidth-1:0] in_data,
  input  logic [1:0]                 in_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [bitwidth-1:0] out_data,
  output logic                       out_ch,
  output logic [4:0]                 out_row,
  output logic [4:0]                 out_col,
  output logic                       out_last
);

  localparam logic [4:0] COL_LAST = 5'(2 * pool_dim - 1);
  localparam logic [3:0] I_LAST   = 4'(pool_dim - 1);
  localparam logic       CH_LAST  = 1'(num_ch - 1);

  typedef struct packed {
    logic signed [bitwidth-1:0] value;
    pos_t                       idx;
  } entry_t;

  phase_t     state;
  logic [3:0] i;
  logic [4:0] col;
  logic       ch;

  entry_t                   wr_ent, rd_ent, beat_ent;
  logic [$bits(entry_t)-1:0] rd_raw;
  logic slot_free, top_even, accept, load, match;

  assign slot_free = !out_valid || out_ready;
  assign top_even  = (state == TOP) && !col[0];
  assign in_ready  = top_even && slot_free && !rst;
  assign accept    = in_valid && in_ready;
  // Even-col beats of a TOP row come straight from the input; all others replay the line buffer.
  assign load      = top_even ? accept : slot_free;

  assign wr_ent   = '{value: in_data, idx: pos_t'(in_idx)};
  assign rd_ent   = entry_t'(rd_raw);
  assign beat_ent = top_even ? wr_ent : rd_ent;

`ifdef MAXUNPOOL_NEAREST_EN
  assign match = 1'b1;
`else
  assign match = (beat_ent.idx == pos_of(state == BOT, col[0]));
`endif

  unpool_line_buf #(
    .depth (pool_dim),
    .width ($bits(entry_t)),
    .aw    (4)
  ) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .waddr (col[4:1]),
    .wdata (wr_ent),
    .raddr (col[4:1]),
    .rdata (rd_raw)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= TOP;
      i         <= '0;
      col       <= '0;
      ch        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= match ? beat_ent.value : '0;
      out_ch    <= ch;
      out_row   <= {i, state == BOT};
      out_col   <= col;
      out_last  <= (ch == CH_LAST) && (i == I_LAST) && (state == BOT) && (col == COL_LAST);
      if (col == COL_LAST) begin
        col <= '0;
        if (state == TOP) begin
          state <= BOT;
        end else begin
          state <= TOP;
          if (i == I_LAST) begin
            i  <= '0;
            ch <= (ch == CH_LAST) ? 1'b0 : ch + 1'b1;
          end else begin
            i <= i + 4'd1;
          end
        end
      end else begin
        col <= col + 5'd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxunpool_1.sv
// Directed bench for maxunpool_1: per-beat scoreboard from the pooled inputs plus hand-picked spot values.
module tb_maxunpool_1;

  localparam int FB = 1568;
`ifdef MAXUNPOOL_NEAREST_EN
  localparam bit NEAR = 1'b1;
`else
  localparam bit NEAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_ch, out_last;
  logic signed [15:0] in_data, out_data;
  logic [1:0] in_idx;
  logic [4:0] out_row, out_col;

  always #5 clk = ~clk;

  maxunpool_1 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_idx(in_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col), .out_last(out_last)
  );

  int n_chk = 0, n_pass = 0;
  logic signed [15:0] ev [$];
  logic [1:0] ei [$];
  logic [15:0] seen [2][28][28];
  int last_cnt, rdy_err, run_cyc, beats;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected {ch, row, col, last, data} of beat b, looked up directly in the pooled input list.
  function automatic logic [27:0] exp_beat(input int b);
    int f, k, ch, r, c, n;
    logic [15:0] v;
    f = b / FB; k = b % FB; ch = k / 784; r = (k % 784) / 28; c = k % 28;
    n = f * 392 + ch * 196 + (r / 2) * 14 + c / 2;
    v = (NEAR || ei[n] == 2'((c % 2) * 2 + r % 2)) ? ev[n] : 16'h0;
    return {1'(ch), 5'(r), 5'(c), (k == FB - 1), v};
  endfunction

  task automatic run(input int nbeats, input bit toggle);
    int ptr, cyc, pos, r, c;
    logic [27:0] e, hold;
    logic exp_rdy, acc, xfer;
    bit held;
    ptr = 0; cyc = 0; beats = 0; last_cnt = 0; rdy_err = 0; held = 0;
    while (beats < nbeats && cyc < nbeats * 4 + 50) begin
      @(negedge clk);
      out_ready = toggle ? cyc[0] : 1'b1;
      if (ptr < ev.size()) begin
        in_valid = 1'b1; in_data = ev[ptr]; in_idx = ei[ptr];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        check("stall_hold", {out_valid, out_ch, out_row, out_col, out_last, out_data}, {1'b1, hold});
        held = 0;
      end
      // Input may only be taken when the next beat to load is an even-row, even-col position.
      pos = (beats + (out_valid ? 1 : 0)) % FB;
      r = (pos % 784) / 28; c = pos % 28;
      exp_rdy = (!out_valid || out_ready) && (r % 2 == 0) && (c % 2 == 0);
      if (in_ready !== exp_rdy) rdy_err++;
      acc = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        e = exp_beat(beats);
        check($sformatf("beat%0d", beats), {out_ch, out_row, out_col, out_last, out_data}, e);
        seen[e[27]][e[26:22]][e[21:17]] = out_data;
        if (out_last) last_cnt++;
        beats++;
      end else if (out_valid) begin
        held = 1;
        hold = {out_ch, out_row, out_col, out_last, out_data};
      end
      @(posedge clk);
      if (acc) ptr++;
      cyc++;
    end
    run_cyc = cyc;
    if (beats < nbeats) check("timeout_beats", beats, nbeats);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 16'sh1234; in_idx = 2'd3; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ch", out_ch, 0);
    check("rst_row", out_row, 0);
    check("rst_col", out_col, 0);
    check("rst_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;

    // Two back-to-back frames, idx=3, continuous sink.
    for (int f = 0; f < 2; f++)
      for (int ch = 0; ch < 2; ch++)
        for (int i = 0; i < 14; i++)
          for (int j = 0; j < 14; j++) begin
            ev.push_back(16'(i * 14 + j + 1));
            ei.push_back(2'd3);
          end
    run(2 * FB, 1'b0);
    check("t1_cycles", run_cyc, 2 * FB + 1);
    check("t1_last_cnt", last_cnt, 2);
    check("t1_in_ready", rdy_err, 0);
    check("t1_r1c1", seen[0][1][1], 1);
    check("t1_r27c27", seen[0][27][27], 196);
    check("t1_ch1_r27c27", seen[1][27][27], 196);
    check("t1_r0c0", seen[0][0][0], NEAR ? 16'd1 : 16'd0);

    // Negative values, rotating idx, sink stalls every other cycle.
    ev.delete(); ei.delete();
    for (int n = 0; n < 392; n++) begin
      ev.push_back(-16'sd5);
      ei.push_back(2'(n % 4));
    end
    run(FB, 1'b1);
    check("t2_r1c2", seen[0][1][2], 16'hFFFB);
    check("t2_r0c2", seen[0][0][2], NEAR ? 16'hFFFB : 16'h0);
    check("t2_r0c3", seen[0][0][3], NEAR ? 16'hFFFB : 16'h0);
    check("t2_r1c3", seen[0][1][3], NEAR ? 16'hFFFB : 16'h0);
    check("t2_r0c0", seen[0][0][0], 16'hFFFB);
    check("t2_last_cnt", last_cnt, 1);
    check("t2_in_ready", rdy_err, 0);

    // Abandon a frame mid-channel with reset.
    ev.delete(); ei.delete();
    for (int n = 0; n < 392; n++) begin
      ev.push_back(16'(3000 + n));
      ei.push_back(2'd0);
    end
    run(500, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_in_ready", in_ready, 0);
    rst = 1'b0;

    ev.delete(); ei.delete();
    for (int n = 0; n < 392; n++) begin
      ev.push_back(n == 1 ? 16'sd7 : 16'(5000 + n));
      ei.push_back(n == 1 ? 2'd2 : 2'd0);
    end
    run(FB, 1'b0);
    check("t4_first_beat", seen[0][0][0], 5000);
    check("t4_cycles", run_cyc, FB + 1);
    check("t4_last_cnt", last_cnt, 1);
    check("t6_r0c3", seen[0][0][3], 7);
    check("t6_r0c2", seen[0][0][2], NEAR ? 16'd7 : 16'd0);
    check("t6_r1c2", seen[0][1][2], NEAR ? 16'd7 : 16'd0);
    check("t6_r1c3", seen[0][1][3], NEAR ? 16'd7 : 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
